jump_pc_buffer: RTL
===================

// Module: jump_pc_buffer
// PURPOSE
//  Per-entry PC / JALR-target store for the jump reservation station.
//  - Captures the instruction PC at enqueue and the JALR target when the FTQ read returns, which can be one or more cycles later.
//  - At issue, presents both values, registered, to the jump immediate-substitution stage of the data array.
//  - Tracks per-entry validity so issue logic can hold an entry whose target has not yet arrived.
// PARAMETERS
//  NUM_ENTRIES  16  RS entries tracked
//  IDX_W        4   entry index width; must satisfy 2^IDX_W >= NUM_ENTRIES
//  VADDR_BITS   39  virtual address width of PC and target
// PORTS
//  clock          in   1           single clock, all state on rising edge
//  reset          in   1           synchronous, active-high
//  io_flush       in   1           redirect: invalidate every entry
//  io_enq_valid   in   1           allocate entry, write PC
//  io_enq_idx     in   IDX_W       entry being allocated
//  io_enq_pc      in   VADDR_BITS  instruction PC
//  io_tgt_valid   in   1           FTQ target return
//  io_tgt_idx     in   IDX_W       entry receiving the target
//  io_tgt_data    in   VADDR_BITS  JALR target
//  io_free_valid  in   1           entry deallocated (issued or squashed)
//  io_free_idx    in   IDX_W       entry freed
//  io_deq_valid   in   1           issue read request
//  io_deq_idx     in   IDX_W       entry read
//  io_out_valid   out  1           read data valid (1-cycle latency)
//  io_out_pc      out  VADDR_BITS  PC of the read entry
//  io_out_target  out  VADDR_BITS  target of the read entry
//  io_out_pc_ok   out  1           PC was valid at read time
//  io_out_tgt_ok  out  1           target was valid at read time
// BEHAVIOUR
//  State per entry: pc_v, tgt_v, pc[VADDR_BITS], tgt[VADDR_BITS].
//  Reset:
//  - All pc_v and tgt_v are 0; pc/tgt arrays are not reset.
//  - All outputs are 0 in the cycle after reset is asserted.
//  Enqueue (io_enq_valid): pc <= io_enq_pc; pc_v <= 1; tgt_v <= 0, unless a target write to the same index occurs in the same cycle.
//  Target write (io_tgt_valid): tgt <= io_tgt_data; tgt_v <= 1. Does not require pc_v.
//  Free (io_free_valid): pc_v <= 0, tgt_v <= 0. Data is retained.
//  Same-index priority, highest first:
//  - flush > enq/tgt > free.
//  - enq and tgt to the same index in the same cycle: both apply, so pc_v=1 and tgt_v=1.
//  - free and enq to the same index: enq wins, and tgt_v=0 unless tgt also hits that index.
//  Flush: all pc_v and tgt_v are 0 next cycle, and io_out_valid is 0 next cycle even if io_deq_valid was 1.
//  Index >= NUM_ENTRIES on any write, free or read port: ignored. A read with such an index returns out_valid=1 with pc_ok=0 and tgt_ok=0.
//  Read path:
//  - Latency is exactly 1 cycle. io_deq_* sampled in cycle N appears on io_out_* in cycle N+1.
//  - Outputs hold their values while io_deq_valid=0. io_out_valid then drops to 0; pc, target and ok flags keep their last values.
//  - Bypass: an enq or tgt write to io_deq_idx in cycle N is visible in the cycle N+1 output, with the new data and ok=1.
//  - Free in cycle N does not affect the cycle N read result: the read sees the pre-free state.
//  Output widths are raw VADDR_BITS. The downstream stage sign-extends the PC and zero-extends the target to 64 bits; this block does no extension.
//  Multiple ports may hit different indices in the same cycle; all updates apply independently.
// TESTING
//  T1 reset:
//  - Stimulus: assert reset, then read idx 3.
//  - Required: out_valid=1, pc_ok=0, tgt_ok=0 one cycle after the read; all outputs 0 while in reset.
//  T2 basic:
//  - Stimulus: enq idx 5 pc=0x40_0000_1000, tgt idx 5 data=0x00_8000_0040 two cycles later, then read idx 5.
//  - Required: pc=0x4000001000, target=0x0080000040, both ok=1.
//  T3 bypass:
//  - Stimulus: enq idx 2 pc=0x7F_FFFF_FFFC, tgt idx 2, and read idx 2, all in the same cycle.
//  - Required: next cycle shows the new pc and target with both ok=1.
//  T4 collisions:
//  - Stimulus: free idx 7 and enq idx 7 in the same cycle.
//  - Required: pc_v=1, tgt_v=0; a later read gives pc_ok=1, tgt_ok=0.
//  T5 flush:
//  - Stimulus: fill entries 0..15, then assert flush together with read idx 0 and enq idx 1.
//  - Required: next cycle out_valid=0; all subsequent reads return ok=0.
//  T6 out-of-range:
//  - Stimulus: set NUM_ENTRIES=12, enq idx 13, then read idx 13.
//  - Required: no state change; pc_ok=0, tgt_ok=0.

Source files
------------

// File: rtl/jump_pc_buffer.sv
// Per-entry PC / JALR-target store for the jump reservation station.
// Entries are written at enqueue and at FTQ return; issue reads them back one cycle later.
module jump_pc_buffer #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int VADDR_BITS  = 39
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_flush,
  input  logic                  io_enq_valid,
  input  logic [IDX_W-1:0]      io_enq_idx,
  input  logic [VADDR_BITS-1:0] io_enq_pc,
  input  logic                  io_tgt_valid,
  input  logic [IDX_W-1:0]      io_tgt_idx,
  input  logic [VADDR_BITS-1:0] io_tgt_data,
  input  logic                  io_free_valid,
  input  logic [IDX_W-1:0]      io_free_idx,
  input  logic                  io_deq_valid,
  input  logic [IDX_W-1:0]      io_deq_idx,
  output logic                  io_out_valid,
  output logic [VADDR_BITS-1:0] io_out_pc,
  output logic [VADDR_BITS-1:0] io_out_target,
  output logic                  io_out_pc_ok,
  output logic                  io_out_tgt_ok
);

  // Handshake: every request port is valid-only and always accepted in the cycle
  // it is asserted (no ready/backpressure); io_out_valid qualifies a read result.

  logic [NUM_ENTRIES-1:0] pc_v;
  logic [NUM_ENTRIES-1:0] tgt_v;
  logic [VADDR_BITS-1:0]  pc_mem  [NUM_ENTRIES];
  logic [VADDR_BITS-1:0]  tgt_mem [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] enq_hit;
  logic [NUM_ENTRIES-1:0] tgt_hit;
  logic [NUM_ENTRIES-1:0] free_hit;

  // Indices at or above NUM_ENTRIES never match an entry, so such writes drop out.
  always_comb begin
    enq_hit  = '0;
    tgt_hit  = '0;
    free_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      enq_hit[i]  = !io_flush && io_enq_valid  && (io_enq_idx  == IDX_W'(i));
      tgt_hit[i]  = !io_flush && io_tgt_valid  && (io_tgt_idx  == IDX_W'(i));
      free_hit[i] = !io_flush && io_free_valid && (io_free_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      pc_v  <= '0;
      tgt_v <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (enq_hit[i])
          pc_v[i] <= 1'b1;
        else if (free_hit[i])
          pc_v[i] <= 1'b0;
        // A new allocation invalidates any stale target unless one lands now.
        if (tgt_hit[i])
          tgt_v[i] <= 1'b1;
        else if (enq_hit[i] || free_hit[i])
          tgt_v[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (enq_hit[i])
        pc_mem[i] <= io_enq_pc;
      if (tgt_hit[i])
        tgt_mem[i] <= io_tgt_data;
    end
  end

  logic deq_in_range;
  logic rd_enq_byp;
  logic rd_tgt_byp;

  always_comb begin
    deq_in_range = (int'(io_deq_idx) < NUM_ENTRIES);
    rd_enq_byp   = io_enq_valid && (io_enq_idx == io_deq_idx);
    rd_tgt_byp   = io_tgt_valid && (io_tgt_idx == io_deq_idx);
  end

  // Reads see same-cycle enq/tgt writes but the pre-free validity.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_valid  <= 1'b0;
      io_out_pc     <= '0;
      io_out_target <= '0;
      io_out_pc_ok  <= 1'b0;
      io_out_tgt_ok <= 1'b0;
    end else if (io_flush || !io_deq_valid) begin
      io_out_valid <= 1'b0;
    end else begin
      io_out_valid <= 1'b1;
      if (deq_in_range) begin
        io_out_pc     <= rd_enq_byp ? io_enq_pc   : pc_mem[io_deq_idx];
        io_out_target <= rd_tgt_byp ? io_tgt_data : tgt_mem[io_deq_idx];
        io_out_pc_ok  <= rd_enq_byp || pc_v[io_deq_idx];
        io_out_tgt_ok <= rd_tgt_byp || (!rd_enq_byp && tgt_v[io_deq_idx]);
      end else begin
        io_out_pc     <= '0;
        io_out_target <= '0;
        io_out_pc_ok  <= 1'b0;
        io_out_tgt_ok <= 1'b0;
      end
    end
  end

endmodule
